// File: rtl/friscv_h.sv
// Shared definitions for the friscv register file: register-count helper,
// ABI register-number constants and the 5-bit register address type.
// Ports: none (package).
package friscv_h;

   typedef logic [4:0] reg_addr_t;

   localparam reg_addr_t ZERO = 5'd0,  RA  = 5'd1,  SP  = 5'd2,  GP  = 5'd3;
   localparam reg_addr_t TP   = 5'd4,  T0  = 5'd5,  T1  = 5'd6,  T2  = 5'd7;
   localparam reg_addr_t S0   = 5'd8,  S1  = 5'd9,  A0  = 5'd10, A1  = 5'd11;
   localparam reg_addr_t A2   = 5'd12, A3  = 5'd13, A4  = 5'd14, A5  = 5'd15;
   localparam reg_addr_t A6   = 5'd16, A7  = 5'd17, S2  = 5'd18, S3  = 5'd19;
   localparam reg_addr_t S4   = 5'd20, S5  = 5'd21, S6  = 5'd22, S7  = 5'd23;
   localparam reg_addr_t S8   = 5'd24, S9  = 5'd25, S10 = 5'd26, S11 = 5'd27;
   localparam reg_addr_t T3   = 5'd28, T4  = 5'd29, T5  = 5'd30, T6  = 5'd31;

   // Number of architectural registers: RV32E keeps only x0..x15.
   function automatic int get_regnum(input int rv32e);
      return (rv32e != 0) ? 16 : 32;
   endfunction

endpackage

// File: rtl/friscv_regfile_merge.sv
// Next-value byte-lane merge for one register across all write ports.
// Latency: combinational. Backpressure: none, every qualified write is taken.
// Ports: cur (current value), wr_* (all write ports, flattened), nxt (merged value).
module friscv_regfile_merge
#(
   parameter int XLEN       = 32,
   parameter int NB_WR_PORT = 4,
   parameter int REG_IDX    = 1
)(
   input  logic [XLEN-1:0]              cur,
   input  logic [NB_WR_PORT-1:0]        wr_en,
   input  logic [NB_WR_PORT*5-1:0]      wr_addr,
   input  logic [NB_WR_PORT*XLEN-1:0]   wr_val,
   input  logic [NB_WR_PORT*XLEN/8-1:0] wr_strb,
   output logic [XLEN-1:0]              nxt
);

   localparam int NBYTE = XLEN / 8;
   localparam logic [4:0] IDX = 5'(REG_IDX);

   // Walk ports from highest to lowest index so the lowest index
   // overwrites last and therefore wins each lane it strobes.
   always_comb begin
      nxt = cur;
      for (int p = NB_WR_PORT - 1; p >= 0; p--) begin
         if (wr_en[p] && wr_addr[p*5 +: 5] == IDX) begin
            for (int b = 0; b < NBYTE; b++) begin
               if (wr_strb[p*NBYTE + b])
                  nxt[b*8 +: 8] = wr_val[p*XLEN + b*8 +: 8];
            end
         end
      end
   end

endmodule

// File: rtl/friscv_regfile_sb.sv
// Multi-port integer register file with per-register busy scoreboard.
// Latency: writes commit at posedge; reads combinational (or 1 cycle with SYNC_READ).
// Backpressure: rsv_ready low stalls a reservation until the register is released.
// Ports: rd_addr/rd_val/rd_busy (read ports), wr_en/wr_addr/wr_val/wr_strb/wr_rel
// (write + release ports), rsv_valid/rsv_addr/rsv_ready (reservation), busy_vec (debug).
module friscv_regfile_sb
   import friscv_h::*;
#(
   parameter int XLEN       = 32,
   parameter int RV32E      = 0,
   parameter int NB_RD_PORT = 5,
   parameter int NB_WR_PORT = 4,
   parameter int BYPASS     = 1,
   parameter int SYNC_READ  = 0
)(
   input  logic                         aclk,
   input  logic                         aresetn,
   input  logic                         srst,
   input  logic [NB_RD_PORT*5-1:0]      rd_addr,
   output logic [NB_RD_PORT*XLEN-1:0]   rd_val,
   output logic [NB_RD_PORT-1:0]        rd_busy,
   input  logic [NB_WR_PORT-1:0]        wr_en,
   input  logic [NB_WR_PORT*5-1:0]      wr_addr,
   input  logic [NB_WR_PORT*XLEN-1:0]   wr_val,
   input  logic [NB_WR_PORT*XLEN/8-1:0] wr_strb,
   input  logic [NB_WR_PORT-1:0]        wr_rel,
   input  logic                         rsv_valid,
   input  logic [4:0]                   rsv_addr,
   output logic                         rsv_ready,
   output logic [31:0]                  busy_vec
);

   localparam int REGNUM = get_regnum(RV32E);

   // x0 has no storage; index 1..REGNUM-1 only.
   logic [XLEN-1:0]   cur [1:REGNUM-1];
   logic [XLEN-1:0]   nxt [1:REGNUM-1];
   logic [REGNUM-1:1] busy_q;
   logic [REGNUM-1:1] rel_vec;
   logic [REGNUM-1:1] rsv_set;

   logic [NB_RD_PORT*XLEN-1:0] rd_val_c;
   logic [NB_RD_PORT-1:0]      rd_busy_c;

   // ------------------------------------------------------------------
   // Storage: one merge + register per architectural register.
   // ------------------------------------------------------------------
   for (genvar g = 1; g < REGNUM; g++) begin : g_reg
      logic [XLEN-1:0] reg_q;

      friscv_regfile_merge #(
         .XLEN       (XLEN),
         .NB_WR_PORT (NB_WR_PORT),
         .REG_IDX    (g)
      ) u_merge (
         .cur     (cur[g]),
         .wr_en   (wr_en),
         .wr_addr (wr_addr),
         .wr_val  (wr_val),
         .wr_strb (wr_strb),
         .nxt     (nxt[g])
      );

      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn)
            reg_q <= '0;
         else if (srst)
            reg_q <= '0;
         else
            reg_q <= nxt[g];
      end

      assign cur[g] = reg_q;
   end

   // ------------------------------------------------------------------
   // Scoreboard
   // ------------------------------------------------------------------
   // Addresses outside 1..REGNUM-1 (x0, or bit 4 under RV32E) match no
   // entry, so they neither release nor reserve anything.
   always_comb begin
      rel_vec = '0;
      for (int p = 0; p < NB_WR_PORT; p++) begin
         for (int r = 1; r < REGNUM; r++) begin
            if (wr_en[p] && wr_rel[p] && wr_addr[p*5 +: 5] == 5'(r))
               rel_vec[r] = 1'b1;
         end
      end
   end

   // A same-cycle release frees the slot regardless of BYPASS; otherwise
   // back-to-back writers of one register would deadlock.
   always_comb begin
      rsv_ready = 1'b1;
      rsv_set   = '0;
      for (int r = 1; r < REGNUM; r++) begin
         if (rsv_addr == 5'(r)) begin
            rsv_ready  = !busy_q[r] || rel_vec[r];
            rsv_set[r] = rsv_valid && (!busy_q[r] || rel_vec[r]);
         end
      end
   end

   // Release is applied before reserve, so release+reserve ends busy.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn)
         busy_q <= '0;
      else if (srst)
         busy_q <= '0;
      else
         busy_q <= (busy_q & ~rel_vec) | rsv_set;
   end

   assign busy_vec = 32'({busy_q, 1'b0});

   // ------------------------------------------------------------------
   // Read ports
   // ------------------------------------------------------------------
   // With bypass, a read shows what the register will hold after this
   // edge; srst wins over the write, so the bypassed value is 0 then.
   always_comb begin
      rd_val_c  = '0;
      rd_busy_c = '0;
      for (int i = 0; i < NB_RD_PORT; i++) begin
         for (int r = 1; r < REGNUM; r++) begin
            if (rd_addr[i*5 +: 5] == 5'(r)) begin
               if (BYPASS != 0) begin
                  rd_val_c[i*XLEN +: XLEN] = srst ? '0 : nxt[r];
                  rd_busy_c[i]             = busy_q[r] && !rel_vec[r] && !srst;
               end else begin
                  rd_val_c[i*XLEN +: XLEN] = cur[r];
                  rd_busy_c[i]             = busy_q[r];
               end
            end
         end
      end
   end

   if (SYNC_READ != 0) begin : g_sync_rd
      always_ff @(posedge aclk or negedge aresetn) begin
         if (!aresetn) begin
            rd_val  <= '0;
            rd_busy <= '0;
         end else if (srst) begin
            rd_val  <= '0;
            rd_busy <= '0;
         end else begin
            rd_val  <= rd_val_c;
            rd_busy <= rd_busy_c;
         end
      end
   end else begin : g_comb_rd
      assign rd_val  = rd_val_c;
      assign rd_busy = rd_busy_c;
   end

endmodule

// File: tb/tb_friscv_regfile_sb.sv
// Directed bench for friscv_regfile_sb: four instances (bypass, no bypass,
// registered read, RV32E) share one stimulus stream; expected values are
// queued when a step is driven and popped when the outputs are sampled.
module tb_friscv_regfile_sb;

   localparam int XLEN = 32;
   localparam int NR   = 5;
   localparam int NW   = 4;

   logic aclk, aresetn, srst;
   logic [NR*5-1:0]      rd_addr;
   logic [NW-1:0]        wr_en;
   logic [NW*5-1:0]      wr_addr;
   logic [NW*XLEN-1:0]   wr_val;
   logic [NW*XLEN/8-1:0] wr_strb;
   logic [NW-1:0]        wr_rel;
   logic                 rsv_valid;
   logic [4:0]           rsv_addr;

   logic [NR*XLEN-1:0] rd_val_b, rd_val_n, rd_val_s, rd_val_e;
   logic [NR-1:0]      rd_busy_b, rd_busy_n, rd_busy_s, rd_busy_e;
   logic               rsv_ready_b, rsv_ready_n, rsv_ready_s, rsv_ready_e;
   logic [31:0]        busy_vec_b, busy_vec_n, busy_vec_s, busy_vec_e;

   friscv_regfile_sb #(.BYPASS(1), .SYNC_READ(0)) dut_b (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .rd_addr(rd_addr),
      .rd_val(rd_val_b), .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_val(wr_val), .wr_strb(wr_strb), .wr_rel(wr_rel), .rsv_valid(rsv_valid),
      .rsv_addr(rsv_addr), .rsv_ready(rsv_ready_b), .busy_vec(busy_vec_b));

   friscv_regfile_sb #(.BYPASS(0), .SYNC_READ(0)) dut_n (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .rd_addr(rd_addr),
      .rd_val(rd_val_n), .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_val(wr_val), .wr_strb(wr_strb), .wr_rel(wr_rel), .rsv_valid(rsv_valid),
      .rsv_addr(rsv_addr), .rsv_ready(rsv_ready_n), .busy_vec(busy_vec_n));

   friscv_regfile_sb #(.BYPASS(1), .SYNC_READ(1)) dut_s (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .rd_addr(rd_addr),
      .rd_val(rd_val_s), .rd_busy(rd_busy_s), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_val(wr_val), .wr_strb(wr_strb), .wr_rel(wr_rel), .rsv_valid(rsv_valid),
      .rsv_addr(rsv_addr), .rsv_ready(rsv_ready_s), .busy_vec(busy_vec_s));

   friscv_regfile_sb #(.RV32E(1), .BYPASS(1), .SYNC_READ(0)) dut_e (
      .aclk(aclk), .aresetn(aresetn), .srst(srst), .rd_addr(rd_addr),
      .rd_val(rd_val_e), .rd_busy(rd_busy_e), .wr_en(wr_en), .wr_addr(wr_addr),
      .wr_val(wr_val), .wr_strb(wr_strb), .wr_rel(wr_rel), .rsv_valid(rsv_valid),
      .rsv_addr(rsv_addr), .rsv_ready(rsv_ready_e), .busy_vec(busy_vec_e));

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   logic [63:0] sb_q[$];
   int checks   = 0;
   int failures = 0;

   task automatic push(input logic [63:0] v);
      sb_q.push_back(v);
   endtask

   task automatic chk(input string tag, input logic [63:0] obs);
      logic [63:0] exp;
      checks++;
      if (sb_q.size() == 0) begin
         failures++;
         $display("FAIL %s observed=%h expected=<empty scoreboard>", tag, obs);
         return;
      end
      exp = sb_q.pop_front();
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clr();
      wr_en     = '0;
      wr_addr   = '0;
      wr_val    = '0;
      wr_strb   = '0;
      wr_rel    = '0;
      rsv_valid = 1'b0;
      rsv_addr  = '0;
   endtask

   task automatic wr(input int p, input logic [4:0] a, input logic [31:0] v,
                     input logic [3:0] s, input logic rel);
      wr_en[p]          = 1'b1;
      wr_addr[p*5 +: 5] = a;
      wr_val[p*32 +: 32] = v;
      wr_strb[p*4 +: 4] = s;
      wr_rel[p]         = rel;
   endtask

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   initial begin
      aresetn = 1'b0;
      srst    = 1'b0;
      clr();
      rd_addr = {5'd5, 5'd4, 5'd3, 5'd2, 5'd1};
      repeat (2) @(posedge aclk);
      #3 aresetn = 1'b1;
      tick();

      // Reset state
      push(0); chk("rst_rd_val", 64'((|rd_val_b) | (|rd_val_n) | (|rd_val_s)));
      push(0); chk("rst_rd_busy", 64'({rd_busy_b, rd_busy_n, rd_busy_s}));
      push(0); chk("rst_busy_vec", 64'(busy_vec_b));
      push(1); chk("rst_rsv_ready", 64'(rsv_ready_b));

      // Read ports: 0->x5 1->x7 2->x10 3->x0 4->x20
      rd_addr = {5'd20, 5'd0, 5'd10, 5'd7, 5'd5};

      // Write-to-read bypass vs registered view
      wr(1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0);
      #1;
      push(64'hDEADBEEF); chk("byp_same_cycle", 64'(rd_val_b[31:0]));
      push(0);            chk("nobyp_same_cycle", 64'(rd_val_n[31:0]));
      tick(); clr(); #1;
      push(64'hDEADBEEF); chk("nobyp_next_cycle", 64'(rd_val_n[31:0]));
      push(64'hDEADBEEF); chk("sync_read_next", 64'(rd_val_s[31:0]));

      // Two ports, overlapping lanes on x7: port0 owns lanes 0-1
      wr(0, 5'd7, 32'h11111111, 4'h3, 1'b0);
      wr(2, 5'd7, 32'h22222222, 4'hF, 1'b0);
      tick(); clr(); #1;
      push(64'h22221111); chk("merge_prio", 64'(rd_val_n[63:32]));

      // Reserve x10, then stall on a second reservation
      rsv_valid = 1'b1; rsv_addr = 5'd10;
      #1;
      push(1); chk("rsv_first_ready", 64'(rsv_ready_b));
      tick(); #1;
      push(1); chk("rsv_rd_busy", 64'(rd_busy_b[2]));
      push(0); chk("rsv_stall", 64'(rsv_ready_b));
      // Release on port 3 in the same cycle as the held reservation
      wr(3, 5'd10, 32'h42, 4'hF, 1'b1);
      #1;
      push(1); chk("rsv_rel_nobyp_ready", 64'(rsv_ready_n));
      push(0); chk("byp_rel_busy", 64'(rd_busy_b[2]));
      push(1); chk("nobyp_rel_busy", 64'(rd_busy_n[2]));
      tick(); clr(); #1;
      push(64'h42); chk("rel_write_val", 64'(rd_val_b[95:64]));
      push(1);      chk("rel_rsv_busy_vec", 64'(busy_vec_b[10]));
      push(0);      chk("sync_busy_ignores_rsv", 64'(rd_busy_s[2]));

      // Release with no strobes only clears busy
      wr(3, 5'd10, 32'hFFFFFFFF, 4'h0, 1'b1);
      tick(); clr(); #1;
      push(64'h42); chk("rel_only_val", 64'(rd_val_n[95:64]));
      push(0);      chk("rel_only_busy", 64'(busy_vec_n[10]));

      // x0: reservation accepted but inert, writes dropped
      rsv_valid = 1'b1; rsv_addr = 5'd0;
      wr(0, 5'd0, 32'hFFFFFFFF, 4'hF, 1'b0);
      #1;
      push(1); chk("rsv_x0_ready", 64'(rsv_ready_b));
      push(0); chk("x0_byp_val", 64'(rd_val_b[127:96]));
      tick(); clr(); #1;
      push(0); chk("x0_val", 64'(rd_val_n[127:96]));
      push(0); chk("x0_busy_vec", 64'(busy_vec_b));

      // Release of a register that is not busy
      wr(0, 5'd11, 32'h0, 4'h0, 1'b1);
      tick(); clr(); #1;
      push(0); chk("rel_nonbusy", 64'(busy_vec_b));

      // srst beats a same-cycle write and reservation
      rd_addr[15 +: 5] = 5'd6;
      wr(0, 5'd6, 32'h1234, 4'hF, 1'b0);
      tick(); clr(); #1;
      push(64'h1234); chk("pre_srst_val", 64'(rd_val_n[127:96]));
      srst = 1'b1;
      wr(0, 5'd6, 32'h5555, 4'hF, 1'b0);
      rsv_valid = 1'b1; rsv_addr = 5'd6;
      tick(); srst = 1'b0; clr(); #1;
      push(0); chk("srst_val", 64'(rd_val_n[127:96]));
      push(0); chk("srst_busy", 64'(busy_vec_n));

      // Async reset in the middle of a burst on x12
      rd_addr[15 +: 5] = 5'd12;
      wr(0, 5'd12, 32'h5, 4'hF, 1'b0);
      rsv_valid = 1'b1; rsv_addr = 5'd12;
      tick(); clr(); #1;
      push(64'h5); chk("pre_arst_val", 64'(rd_val_n[127:96]));
      push(1);     chk("pre_arst_busy", 64'(busy_vec_n[12]));
      wr(1, 5'd12, 32'h99, 4'hF, 1'b0);
      aresetn = 1'b0;
      #1;
      push(0); chk("arst_val", 64'(rd_val_n[127:96]));
      push(0); chk("arst_busy", 64'(busy_vec_n));
      clr();
      #2 aresetn = 1'b1;
      tick();
      push(0); chk("post_arst_val", 64'(rd_val_b[127:96]));

      // RV32E: x20 is out of range, x4 still works
      rd_addr[15 +: 5] = 5'd4;
      wr(0, 5'd20, 32'hABCD, 4'hF, 1'b0);
      wr(1, 5'd4, 32'h77, 4'hF, 1'b0);
      rsv_valid = 1'b1; rsv_addr = 5'd20;
      #1;
      push(0); chk("e_x20_byp", 64'(rd_val_e[159:128]));
      push(1); chk("e_rsv_x20_ready", 64'(rsv_ready_e));
      tick(); clr(); #1;
      push(0);        chk("e_x20_val", 64'(rd_val_e[159:128]));
      push(0);        chk("e_busy_vec", 64'(busy_vec_e));
      push(64'h77);   chk("e_x4_val", 64'(rd_val_e[127:96]));
      push(64'hABCD); chk("full_x20_val", 64'(rd_val_b[159:128]));
      push(1);        chk("full_x20_busy", 64'(busy_vec_b[20]));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
